// File: rtl/uart_receive.sv
// UART receiver: 8N1 frames at CLKS_PER_BIT clocks per bit, held valid/ack byte
// interface, one-cycle framing-error and overrun pulses.
module uart_receive #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4
  } state_t;

  logic        rx_meta_r;
  logic        rx_s;
  logic [1:0]  settle_r;
  state_t      state_r, state_nxt_s;
  logic [15:0] cnt_r, cnt_nxt_s;
  logic [2:0]  idx_r, idx_nxt_s;
  logic [7:0]  shift_r, shift_nxt_s;
  logic        deliver_s;
  logic        frame_bad_s;

  // Two-flop synchronizer; settle_r keeps the synchronizer's reset value from
  // being mistaken for an idle line right after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rx_s      <= 1'b1;
      settle_r  <= 2'b00;
    end else begin
      rx_meta_r <= Rx;
      rx_s      <= rx_meta_r;
      settle_r  <= {settle_r[0], 1'b1};
    end
  end

  // FSM, bit timer, bit index and shift register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= WAIT_IDLE;
      cnt_r   <= 16'd0;
      idx_r   <= 3'd0;
      shift_r <= 8'h00;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      idx_r   <= idx_nxt_s;
      shift_r <= shift_nxt_s;
    end
  end

  // Next-state logic: sample at mid start bit, then every full bit period.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    idx_nxt_s   = idx_r;
    shift_nxt_s = shift_r;
    deliver_s   = 1'b0;
    frame_bad_s = 1'b0;
    case (state_r)
      WAIT_IDLE: begin
        if (rx_s && settle_r[1]) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_IDLE;
        end
      end
      IDLE: begin
        if (!rx_s) begin
          state_nxt_s = START;
          cnt_nxt_s   = 16'd0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (cnt_r == HALF_LAST) begin
          cnt_nxt_s = 16'd0;
          idx_nxt_s = 3'd0;
          if (!rx_s) begin
            state_nxt_s = DATA;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          cnt_nxt_s = cnt_r + 16'd1;
        end
      end
      DATA: begin
        if (cnt_r == BIT_LAST) begin
          cnt_nxt_s          = 16'd0;
          shift_nxt_s[idx_r] = rx_s;
          idx_nxt_s          = idx_r + 3'd1;
          if (idx_r == 3'd7) begin
            state_nxt_s = STOP;
          end else begin
            state_nxt_s = DATA;
          end
        end else begin
          cnt_nxt_s = cnt_r + 16'd1;
        end
      end
      STOP: begin
        if (cnt_r == BIT_LAST) begin
          cnt_nxt_s = 16'd0;
          // A low stop bit means break or a dead line: wait for it to go high.
          if (rx_s) begin
            deliver_s   = 1'b1;
            state_nxt_s = IDLE;
          end else begin
            frame_bad_s = 1'b1;
            state_nxt_s = WAIT_IDLE;
          end
        end else begin
          cnt_nxt_s = cnt_r + 16'd1;
        end
      end
      default: begin
        state_nxt_s = WAIT_IDLE;
      end
    endcase
  end

  // Byte handshake and status pulses; an unacknowledged byte is never overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      rx_frame_err <= frame_bad_s;
      rx_overrun   <= 1'b0;
      if (deliver_s) begin
        if (!rx_valid || rx_ack) begin
          rx_data  <= shift_r;
          rx_valid <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receive.sv
// Bench for uart_receive: event-level model of frames and handshake, checked
// every cycle, plus hand-computed literal checks.
module tb_uart_receive;

  localparam int CPB = 13;
  localparam int LAT = 3 + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_line, rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid, rx_frame_err, rx_overrun;
  logic       rx_line_d, ack_d;
  logic [7:0] data_d;
  logic       valid_d, ferr_d, ovr_d;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_ferr = 0;
  int n_ovr = 0;
  int dflags = 0;

  typedef struct {
    int         e;
    bit         good;
    logic [7:0] b;
  } ev_t;
  ev_t ev_q[$];

  logic [7:0] m_data = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_ferr = 1'b0;
  logic       m_ovr = 1'b0;

  uart_receive #(.CLKS_PER_BIT(CPB)) u_dut (
    .clk(clk), .rst_n(rst_n), .Rx(rx_line),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
    .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun)
  );

  uart_receive u_def (
    .clk(clk), .rst_n(rst_n), .Rx(rx_line_d),
    .rx_data(data_d), .rx_valid(valid_d), .rx_ack(ack_d),
    .rx_frame_err(ferr_d), .rx_overrun(ovr_d)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_frame_err) n_ferr <= n_ferr + 1;
    if (rx_overrun) n_ovr <= n_ovr + 1;
    if (ferr_d || ovr_d) dflags <= dflags + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_near(input string nm, input int act, input int exp, input int tol);
    total++;
    if (act < exp - tol || act > exp + tol) begin
      bad++;
      $display("FAIL %s: got %0d want %0d +-%0d", nm, act, exp, tol);
    end
  endtask

  task automatic hold(input logic v, input int n);
    rx_line = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    @(posedge clk);
    #1;
    rx_ack = 1'b0;
  endtask

  // The outcome of a frame appears LAT edges after its start bit is driven.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    ev_t ev;
    ev.e = cyc + LAT;
    ev.good = stop;
    ev.b = b;
    ev_q.push_back(ev);
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
    hold(stop, CPB);
  endtask

  task automatic send_def(input logic [7:0] b);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_line_d = bits[i];
      repeat (868) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    int seen;
    rst_n = 1'b0;
    rx_line = 1'b1;
    rx_ack = 1'b0;
    rx_line_d = 1'b1;
    ack_d = 1'b0;

    fork
      // model: frame outcomes and handshake at each clock edge
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
          m_data = 8'h00; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
          ev_q.delete();
        end else begin
          m_ferr = 1'b0;
          m_ovr = 1'b0;
          if (ev_q.size() > 0 && ev_q[0].e == cyc + 1) begin
            if (!ev_q[0].good) m_ferr = 1'b1;
            else if (!m_valid || rx_ack) begin
              m_data = ev_q[0].b;
              m_valid = 1'b1;
            end else m_ovr = 1'b1;
            void'(ev_q.pop_front());
          end else if (m_valid && rx_ack) m_valid = 1'b0;
        end
      end
      // compare process
      forever begin
        @(negedge clk);
        chk("valid", {31'd0, rx_valid}, {31'd0, m_valid});
        chk("data", {24'd0, rx_data}, {24'd0, m_data});
        chk("frame_err", {31'd0, rx_frame_err}, {31'd0, m_ferr});
        chk("overrun", {31'd0, rx_overrun}, {31'd0, m_ovr});
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", {24'd0, rx_data}, 32'h0);
    chk("rst_valid", {31'd0, rx_valid}, 32'h0);
    chk("rst_data_def", {24'd0, data_d}, 32'h0);
    rst_n = 1'b1;
    hold(1'b1, 8);

    // default-rate instance: latency, data, ack
    c = cyc;
    seen = -1;
    fork
      send_def(8'hA5);
      begin
        for (int k = 0; k < 9000 && seen < 0; k++) begin
          @(posedge clk);
          #1;
          if (valid_d) seen = cyc;
        end
      end
    join
    chk_near("def_latency", seen - c, 8249, 1);
    chk("def_data", {24'd0, data_d}, 32'hA5);
    chk("def_flags", dflags, 0);
    ack_d = 1'b1;
    @(posedge clk);
    #1;
    ack_d = 1'b0;
    chk("def_ack_valid", {31'd0, valid_d}, 32'h0);
    chk("def_ack_data", {24'd0, data_d}, 32'hA5);

    // back-to-back 0x00, 0xFF
    hold(1'b1, 5);
    c = cyc;
    fork
      begin send_frame(8'h00, 1'b1); send_frame(8'hFF, 1'b1); end
      begin
        wait_until(c + LAT + 2);
        chk("b2b_first", {23'd0, rx_valid, rx_data}, 32'h100);
        pulse_ack();
        wait_until(c + 10 * CPB + LAT + 2);
        chk("b2b_second", {23'd0, rx_valid, rx_data}, 32'h1FF);
        pulse_ack();
      end
    join

    // framing error, long low line, recovery
    send_frame(8'h3C, 1'b0);
    hold(1'b0, 500);
    hold(1'b1, 20);
    send_frame(8'h5A, 1'b1);
    hold(1'b1, 5);
    chk("ferr_count", n_ferr, 1);
    chk("after_break", {23'd0, rx_valid, rx_data}, 32'h15A);
    pulse_ack();

    // short glitch rejected, then 0x81 with literal latency
    hold(1'b0, 3);
    hold(1'b1, 20);
    c = cyc;
    fork
      send_frame(8'h81, 1'b1);
      begin
        wait_until(c + LAT - 1);
        chk("lat_before", {31'd0, rx_valid}, 32'h0);
        wait_until(c + 126);
        chk("lat_at", {23'd0, rx_valid, rx_data}, 32'h181);
      end
    join
    chk("glitch_ferr", n_ferr, 1);
    pulse_ack();

    // overrun, then ack coinciding with delivery
    hold(1'b1, 5);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    hold(1'b1, 5);
    chk("ovr_count", n_ovr, 1);
    chk("ovr_keep", {23'd0, rx_valid, rx_data}, 32'h111);
    c = cyc;
    fork
      send_frame(8'h22, 1'b1);
      begin
        wait_until(c + LAT - 1);
        rx_ack = 1'b1;
        @(posedge clk);
        #1;
        rx_ack = 1'b0;
      end
    join
    chk("ack_ovr_count", n_ovr, 1);
    chk("ack_on_deliver", {23'd0, rx_valid, rx_data}, 32'h122);

    // reset in the middle of 0x77, released with the line low
    hold(1'b1, 5);
    hold(1'b0, CPB);
    for (int i = 0; i < 3; i++) hold(1'b1, CPB);
    rx_line = 1'b0;
    rst_n = 1'b0;
    hold(1'b0, 4);
    chk("midrst", {23'd0, rx_valid, rx_data}, 32'h0);
    rst_n = 1'b1;
    hold(1'b0, 40);
    chk("low_after_rst", n_ferr, 1);
    chk("low_after_rst_valid", {31'd0, rx_valid}, 32'h0);
    hold(1'b1, 20);
    send_frame(8'h42, 1'b1);
    hold(1'b1, 5);
    chk("after_rst", {23'd0, rx_valid, rx_data}, 32'h142);
    pulse_ack();
    hold(1'b1, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
